mem_arbiter: RTL and testbench

//  Owns the single byte-serial memory controller port and shares it between the instruction

---
 rtl/mem_arbiter_pkg.sv | 39 +++
 rtl/mem_arb_picker.sv | 33 +++
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: LS type codes, IO map, FSM encodings, payload.
package mem_arbiter_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned DEF_STARVE_LIMIT = 4;
  localparam logic [XLEN-1:0] DEF_IO_BASE  = 32'h0003_0000;

  // Load/store type codes: [1:0] 00 word / 01 half / 10 byte, [2] sign-extend
  localparam logic [2:0] LS_LW  = 3'b000;
  localparam logic [2:0] LS_LH  = 3'b101;
  localparam logic [2:0] LS_LB  = 3'b110;
  localparam logic [2:0] LS_LHU = 3'b001;
  localparam logic [2:0] LS_LBU = 3'b010;
  localparam logic [2:0] LS_SW  = 3'b000;
  localparam logic [2:0] LS_SH  = 3'b001;
  localparam logic [2:0] LS_SB  = 3'b010;

  // Arbiter FSM encodings
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BUSY_IC  = 3'd1;
  localparam logic [2:0] ST_BUSY_LSB = 3'd2;
  localparam logic [2:0] ST_RESP     = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;

  // Payload latched toward the memory controller at grant
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            r_nw;
    logic [2:0]      kind;
  } mem_req_t;

  // Stores into IO space must wait while the IO write buffer is full
  function automatic logic is_io_store(input logic [XLEN-1:0] addr, input logic r_nw,
                                       input logic [XLEN-1:0] io_base);
    return !r_nw && (addr >= io_base);
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational grant choice between icache and LSB with starvation bound and IO-store gate.
module mem_arb_picker
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned     STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter logic [XLEN-1:0] IO_BASE      = DEF_IO_BASE,
  parameter int unsigned     CNT_W        = 3
) (
  input  logic             ic_req,
  input  logic             flush,
  input  logic             lsb_req,
  input  logic [XLEN-1:0]  lsb_addr,
  input  logic             lsb_r_nw,
  input  logic             io_buffer_full,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant_ic_c,
  output logic             grant_lsb_c
);

  logic ic_ok;
  logic lsb_ok;
  logic starved;

  // LSB normally wins; icache wins when alone or once the LSB has used up its streak
  always_comb begin
    ic_ok       = ic_req && !flush;
    lsb_ok      = lsb_req && !(io_buffer_full && is_io_store(lsb_addr, lsb_r_nw, IO_BASE));
    starved     = (starve_cnt == CNT_W'(STARVE_LIMIT));
    grant_ic_c  = ic_ok && (!lsb_ok || starved);
    grant_lsb_c = lsb_ok && !grant_ic_c;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory controller port between icache fetches and LSB accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned     STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter logic [XLEN-1:0] IO_BASE      = DEF_IO_BASE
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            ic_req,
  input  logic [XLEN-1:0] ic_addr,
  output logic            ic_done,
  output logic [XLEN-1:0] ic_rdata,
  input  logic            flush,
  input  logic            lsb_req,
  input  logic [XLEN-1:0] lsb_addr,
  input  logic [XLEN-1:0] lsb_wdata,
  input  logic            lsb_r_nw,
  input  logic [2:0]      lsb_type,
  output logic            lsb_done,
  output logic [XLEN-1:0] lsb_rdata,
  output logic            mc_activate,
  output logic [XLEN-1:0] mc_addr,
  output logic [XLEN-1:0] mc_wdata,
  output logic            mc_r_nw,
  output logic [2:0]      mc_type,
  input  logic            mc_data_avail,
  input  logic [XLEN-1:0] mc_data_out,
  input  logic            io_buffer_full
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [2:0]      state, state_d;
  logic [CNT_W-1:0] starve_cnt, starve_d;
  mem_req_t        req_q, req_d;
  logic            own_lsb, own_lsb_d;
  logic [XLEN-1:0] resp_q, resp_d;
  logic            act_d, ic_done_d, lsb_done_d;
  logic [XLEN-1:0] ic_rdata_d, lsb_rdata_d;
  logic            grant_ic_c, grant_lsb_c;

  mem_arb_picker #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .IO_BASE      (IO_BASE),
    .CNT_W        (CNT_W)
  ) u_picker (
    .ic_req         (ic_req),
    .flush          (flush),
    .lsb_req        (lsb_req),
    .lsb_addr       (lsb_addr),
    .lsb_r_nw       (lsb_r_nw),
    .io_buffer_full (io_buffer_full),
    .starve_cnt     (starve_cnt),
    .grant_ic_c     (grant_ic_c),
    .grant_lsb_c    (grant_lsb_c)
  );

  assign mc_addr  = req_q.addr;
  assign mc_wdata = req_q.wdata;
  assign mc_r_nw  = req_q.r_nw;
  assign mc_type  = req_q.kind;

  // Next-state and next-output logic; done pulses are raised on the RESP exit edge
  always_comb begin
    state_d     = state;
    act_d       = mc_activate;
    req_d       = req_q;
    starve_d    = starve_cnt;
    own_lsb_d   = own_lsb;
    resp_d      = resp_q;
    ic_done_d   = 1'b0;
    lsb_done_d  = 1'b0;
    ic_rdata_d  = ic_rdata;
    lsb_rdata_d = lsb_rdata;
    case (state)
      ST_IDLE: begin
        if (grant_lsb_c) begin
          state_d   = ST_BUSY_LSB;
          act_d     = 1'b1;
          own_lsb_d = 1'b1;
          req_d     = '{addr: lsb_addr, wdata: lsb_wdata, r_nw: lsb_r_nw, kind: lsb_type};
          if (ic_req && (starve_cnt != CNT_W'(STARVE_LIMIT)))
            starve_d = starve_cnt + CNT_W'(1);
        end else if (grant_ic_c) begin
          state_d   = ST_BUSY_IC;
          act_d     = 1'b1;
          own_lsb_d = 1'b0;
          req_d     = '{addr: ic_addr, wdata: '0, r_nw: 1'b1, kind: LS_LW};
          starve_d  = '0;
        end
      end
      ST_BUSY_IC: begin
        if (flush) begin
          // cancelled fetch: let the controller finish, then drop the data
          if (mc_data_avail) begin
            state_d = ST_IDLE;
            act_d   = 1'b0;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (mc_data_avail) begin
          state_d = ST_RESP;
          act_d   = 1'b0;
          resp_d  = mc_data_out;
        end
      end
      ST_BUSY_LSB: begin
        if (mc_data_avail) begin
          state_d = ST_RESP;
          act_d   = 1'b0;
          resp_d  = mc_data_out;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (own_lsb) begin
          lsb_done_d  = 1'b1;
          lsb_rdata_d = resp_q;
        end else if (!flush) begin
          ic_done_d  = 1'b1;
          ic_rdata_d = resp_q;
        end
      end
      ST_DRAIN: begin
        if (mc_data_avail) begin
          state_d = ST_IDLE;
          act_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        act_d   = 1'b0;
      end
    endcase
  end

  // FSM state register; rdy_in low freezes it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)      state <= ST_IDLE;
    else if (rdy_in) state <= state_d;
  end

  // Payload, starvation counter and response registers; rdy_in low freezes them
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mc_activate <= 1'b0;
      req_q       <= '0;
      starve_cnt  <= '0;
      own_lsb     <= 1'b0;
      resp_q      <= '0;
      ic_done     <= 1'b0;
      lsb_done    <= 1'b0;
      ic_rdata    <= '0;
      lsb_rdata   <= '0;
    end else if (rdy_in) begin
      mc_activate <= act_d;
      req_q       <= req_d;
      starve_cnt  <= starve_d;
      own_lsb     <= own_lsb_d;
      resp_q      <= resp_d;
      ic_done     <= ic_done_d;
      lsb_done    <= lsb_done_d;
      ic_rdata    <= ic_rdata_d;
      lsb_rdata   <= lsb_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants/responses queued at issue, checked by a monitor.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, ic_req, flush, lsb_req, lsb_r_nw, io_buffer_full;
  logic [31:0] ic_addr, lsb_addr, lsb_wdata, mc_data_out;
  logic [2:0]  lsb_type;
  logic        mc_data_avail;
  logic        ic_done, lsb_done, mc_activate, mc_r_nw;
  logic [31:0] ic_rdata, lsb_rdata, mc_addr, mc_wdata;
  logic [2:0]  mc_type;

  typedef struct {logic [31:0] addr; logic [2:0] kind; logic r_nw; logic [31:0] wdata; int gap;} grant_t;
  typedef struct {logic lsb; logic [31:0] data; int lat;} resp_t;
  typedef struct {logic [31:0] addr; logic [2:0] kind; logic r_nw; logic [31:0] wdata;} lsb_op_t;

  grant_t      exp_grant[$];
  resp_t       exp_resp[$];
  logic [31:0] ic_q[$];
  lsb_op_t     lsb_q[$];

  int   total = 0, bad = 0;
  int   cyc = 0, rise_cyc = 0, fall_cyc = -100;
  logic prev_act = 1'b0;
  int   lat = 4;
  logic stray = 1'b0;

  always #5 clk_in = ~clk_in;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .flush(flush),
    .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata), .lsb_r_nw(lsb_r_nw),
    .lsb_type(lsb_type), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mc_activate(mc_activate), .mc_addr(mc_addr), .mc_wdata(mc_wdata), .mc_r_nw(mc_r_nw),
    .mc_type(mc_type), .mc_data_avail(mc_data_avail), .mc_data_out(mc_data_out),
    .io_buffer_full(io_buffer_full)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (32'hA500_0000 | a);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // Grant and response monitor, sampled on the falling edge
  task automatic monitor_loop();
    grant_t      g;
    resp_t       r;
    logic [31:0] data;
    forever begin
      @(negedge clk_in);
      cyc++;
      if (mc_activate && !prev_act) begin
        if (exp_grant.size() == 0) fail_now("unexpected_grant");
        else begin
          g = exp_grant.pop_front();
          chk("grant_addr", mc_addr, g.addr);
          chk("grant_type", 32'(mc_type), 32'(g.kind));
          chk("grant_rnw", 32'(mc_r_nw), 32'(g.r_nw));
          chk("grant_wdata", mc_wdata, g.wdata);
          chk("idle_gap_min", 32'(cyc - fall_cyc >= 2), 32'd1);
          if (g.gap != 0) chk("grant_gap", 32'(cyc - fall_cyc), 32'(g.gap));
        end
        rise_cyc = cyc;
      end
      if (!mc_activate && prev_act) fall_cyc = cyc;
      if (ic_done || lsb_done) begin
        if (exp_resp.size() == 0) fail_now("unexpected_done");
        else begin
          r = exp_resp.pop_front();
          chk("done_owner", 32'(lsb_done), 32'(r.lsb));
          chk("done_exclusive", 32'(ic_done & lsb_done), 32'd0);
          data = lsb_done ? lsb_rdata : ic_rdata;
          chk("rdata", data, r.data);
          if (r.lat != 0) chk("latency", 32'(cyc - rise_cyc), 32'(r.lat));
        end
      end
      prev_act = mc_activate;
    end
  endtask

  // Memory controller model: completes after lat active, unpaused cycles
  task automatic controller_loop();
    int cnt = 0;
    forever begin
      @(posedge clk_in);
      #2;
      if (rst_in) begin
        mc_data_avail = 1'b0;
        cnt = 0;
      end else if (mc_data_avail) begin
        mc_data_avail = 1'b0;
        mc_data_out = 32'h0;
        cnt = 0;
      end else if (stray && !mc_activate) begin
        mc_data_avail = 1'b1;
        mc_data_out = 32'h1234_5678;
        stray = 1'b0;
      end else if (mc_activate && rdy_in) begin
        cnt++;
        if (cnt == lat) begin
          mc_data_avail = 1'b1;
          mc_data_out = mem_val(mc_addr);
        end
      end
    end
  endtask

  // Advance one cycle; requesters drop on done and present their next queued request
  task automatic step();
    lsb_op_t op;
    @(posedge clk_in);
    #1;
    if (ic_req && ic_done) ic_req = 1'b0;
    if (lsb_req && lsb_done) lsb_req = 1'b0;
    if (!ic_req && ic_q.size() > 0) begin
      ic_addr = ic_q.pop_front();
      ic_req = 1'b1;
    end
    if (!lsb_req && lsb_q.size() > 0) begin
      op = lsb_q.pop_front();
      lsb_addr = op.addr; lsb_type = op.kind; lsb_r_nw = op.r_nw; lsb_wdata = op.wdata;
      lsb_req = 1'b1;
    end
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!mc_activate && n < 50) begin step(); n++; end
    if (!mc_activate) fail_now({name, "_no_grant_timeout"});
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((exp_grant.size() != 0 || exp_resp.size() != 0 || ic_req || lsb_req ||
            ic_q.size() != 0 || lsb_q.size() != 0 || mc_activate) && n < 400) begin
      step(); n++;
    end
    if (n >= 400) fail_now({name, "_quiet_timeout"});
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; ic_req = 1'b0; ic_addr = '0; flush = 1'b0;
    lsb_req = 1'b0; lsb_addr = '0; lsb_wdata = '0; lsb_r_nw = 1'b1; lsb_type = '0;
    io_buffer_full = 1'b0; mc_data_avail = 1'b0; mc_data_out = '0;
    fork
      monitor_loop();
      controller_loop();
    join_none
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_activate", 32'(mc_activate), 32'd0);
    chk("rst_ic_done", 32'(ic_done), 32'd0);
    chk("rst_lsb_done", 32'(lsb_done), 32'd0);
    chk("rst_mc_addr", mc_addr, 32'h0);
    chk("rst_ic_rdata", ic_rdata, 32'h0);
    rst_in = 1'b0;
    step();

    // 1: lone icache fetch
    ic_q.push_back(32'h100);
    exp_grant.push_back('{32'h100, LS_LW, 1'b1, 32'h0, 0});
    exp_resp.push_back('{1'b0, 32'hDEAD_BEEF, 5});
    wait_quiet("t1");

    // 2: simultaneous requests, LSB first, icache in the next free slot
    ic_q.push_back(32'h300);
    lsb_q.push_back('{32'h2000, LS_LW, 1'b1, 32'h0});
    exp_grant.push_back('{32'h2000, LS_LW, 1'b1, 32'h0, 0});
    exp_grant.push_back('{32'h300, LS_LW, 1'b1, 32'h0, 2});
    exp_resp.push_back('{1'b1, 32'hA500_2000, 5});
    exp_resp.push_back('{1'b0, 32'hA500_0300, 5});
    wait_quiet("t2");

    // 3: starvation bound: four LSB grants then icache
    ic_q.push_back(32'h400);
    for (int i = 0; i < 6; i++) lsb_q.push_back('{32'h1000 + 32'(4 * i), LS_LW, 1'b1, 32'h0});
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back('{32'h1000 + 32'(4 * i), LS_LW, 1'b1, 32'h0, (i == 0) ? 0 : 2});
      exp_resp.push_back('{1'b1, 32'hA500_1000 + 32'(4 * i), 5});
    end
    exp_grant.push_back('{32'h400, LS_LW, 1'b1, 32'h0, 2});
    exp_resp.push_back('{1'b0, 32'hA500_0400, 5});
    for (int i = 4; i < 6; i++) begin
      exp_grant.push_back('{32'h1000 + 32'(4 * i), LS_LW, 1'b1, 32'h0, 2});
      exp_resp.push_back('{1'b1, 32'hA500_1000 + 32'(4 * i), 5});
    end
    wait_quiet("t3");

    // 4: flush one cycle after an icache grant drains silently
    ic_q.push_back(32'h180);
    exp_grant.push_back('{32'h180, LS_LW, 1'b1, 32'h0, 0});
    wait_grant("t4");
    flush = 1'b1;
    ic_req = 1'b0;
    step();
    flush = 1'b0;
    chk("drain_state", 32'(dut.state), 32'(ST_DRAIN));
    chk("drain_activate", 32'(mc_activate), 32'd1);
    begin
      int n = 0;
      while (mc_activate && n < 20) begin step(); n++; end
      if (mc_activate) fail_now("drain_timeout");
    end
    repeat (3) step();
    chk("drain_no_ic_done", 32'(ic_done), 32'd0);
    chk("drain_idle", 32'(dut.state), 32'(ST_IDLE));
    ic_q.push_back(32'h200);
    exp_grant.push_back('{32'h200, LS_LW, 1'b1, 32'h0, 0});
    exp_resp.push_back('{1'b0, 32'hA500_0200, 5});
    wait_quiet("t4b");

    // 5: IO store gated while buffer full, icache takes the slot
    io_buffer_full = 1'b1;
    lsb_q.push_back('{32'h3_0000, LS_SB, 1'b0, 32'h77});
    ic_q.push_back(32'h500);
    exp_grant.push_back('{32'h500, LS_LW, 1'b1, 32'h0, 0});
    exp_resp.push_back('{1'b0, 32'hA500_0500, 5});
    repeat (14) step();
    chk("io_store_held", 32'(mc_activate), 32'd0);
    chk("io_ic_served", 32'(exp_resp.size()), 32'd0);
    exp_grant.push_back('{32'h3_0000, LS_SB, 1'b0, 32'h77, 0});
    exp_resp.push_back('{1'b1, 32'hA503_0000, 5});
    io_buffer_full = 1'b0;
    wait_quiet("t5");

    // 6a: asynchronous reset in BUSY_LSB drops the access
    lsb_q.push_back('{32'h2100, LS_LW, 1'b1, 32'h0});
    exp_grant.push_back('{32'h2100, LS_LW, 1'b1, 32'h0, 0});
    wait_grant("t6a");
    step();
    #3 rst_in = 1'b1;
    #1;
    chk("arst_activate", 32'(mc_activate), 32'd0);
    chk("arst_lsb_done", 32'(lsb_done), 32'd0);
    chk("arst_mc_addr", mc_addr, 32'h0);
    chk("arst_state", 32'(dut.state), 32'(ST_IDLE));
    lsb_req = 1'b0;
    lsb_q.delete();
    repeat (2) step();
    rst_in = 1'b0;
    step();

    // 6b: three paused cycles mid-access shift completion by three
    lsb_q.push_back('{32'h2200, LS_LW, 1'b1, 32'h0});
    exp_grant.push_back('{32'h2200, LS_LW, 1'b1, 32'h0, 0});
    exp_resp.push_back('{1'b1, 32'hA500_2200, 8});
    wait_grant("t6b");
    step();
    rdy_in = 1'b0;
    repeat (3) begin
      step();
      chk("pause_activate", 32'(mc_activate), 32'd1);
      chk("pause_mc_addr", mc_addr, 32'h2200);
    end
    rdy_in = 1'b1;
    wait_quiet("t6b");

    // completion pulse while idle is ignored
    stray = 1'b1;
    repeat (4) step();
    chk("stray_no_activate", 32'(mc_activate), 32'd0);
    chk("stray_idle", 32'(dut.state), 32'(ST_IDLE));

    chk("grants_left", 32'(exp_grant.size()), 32'd0);
    chk("resps_left", 32'(exp_resp.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
